// File: rtl/dmem_responder.sv
// RV32I data-memory responder: valid/ready request and response channels, word RAM,
// sub-word loads/stores, WAIT_CYCLES wait states. Define DMEM_MISALIGN_CHECK_EN to reject misaligned H/W accesses.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [2:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic [31:0]   word;
    logic          out_of_range, illegal, misalign, acc_err;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    logic [31:0]   load_data, st_mask, st_data, store_word;
    logic          mem_we;

    assign idx          = addr_q[AW+1:2];
    assign word         = mem[idx];
    assign out_of_range = (addr_q >> (AW + 2)) != '0;
    assign illegal      = we_q ? (size_q > 3'd2)
                               : !(size_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
`ifdef DMEM_MISALIGN_CHECK_EN
    assign misalign = (size_q[1:0] == 2'b01 && addr_q[0]) ||
                      (size_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif
    assign acc_err = out_of_range || illegal || misalign;

    always_comb begin
        byte_v = 8'(word >> {addr_q[1:0], 3'b000});
        half_v = addr_q[1] ? word[31:16] : word[15:0];
        case (size_q)
            3'b000:  load_data = {{24{byte_v[7]}}, byte_v};
            3'b100:  load_data = {24'h0, byte_v};
            3'b001:  load_data = {{16{half_v[15]}}, half_v};
            3'b101:  load_data = {16'h0, half_v};
            default: load_data = word;
        endcase
        case (size_q)
            3'b000: begin
                st_mask = 32'h0000_00FF << {addr_q[1:0], 3'b000};
                st_data = {4{wdata_q[7:0]}};
            end
            3'b001: begin
                st_mask = addr_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                st_data = {2{wdata_q[15:0]}};
            end
            default: begin
                st_mask = '1;
                st_data = wdata_q;
            end
        endcase
        store_word = (word & ~st_mask) | (st_data & st_mask);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    err_d   = acc_err;
                    rdata_d = (acc_err || we_q) ? '0 : load_data;
                    mem_we  = we_q && !acc_err;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // RAM has no reset; write enable derives from state_q, so reset blocks a pending store
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx] <= store_word;
    end

    assign req_ready = (state_q == IDLE) && rst_n;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a byte-level memory model.
module tb_dmem_responder;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned W     = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_size = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] mb [4*DEPTH];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Byte-addressed reference: legality, alignment, extension computed arithmetically
    function automatic void model(input logic we, input logic [2:0] sz, input logic [31:0] a,
                                  input logic [31:0] wd, output logic [31:0] rd, output logic err);
        int unsigned n, base;
        longint unsigned v;
        bit legal;
        rd = '0;
        legal = we ? (sz <= 3'd2) : (sz inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        n = (sz[1:0] == 2'd0) ? 1 : (sz[1:0] == 2'd1) ? 2 : 4;
        err = !legal || (a >= 4 * DEPTH);
`ifdef DMEM_MISALIGN_CHECK_EN
        if (a % n != 0) err = 1'b1;
`endif
        if (err) return;
        base = a - (a % n);
        if (we) begin
            for (int i = 0; i < int'(n); i++) mb[base + i] = wd[8*i +: 8];
        end else begin
            v = 0;
            for (int i = 0; i < int'(n); i++) v = v + (longint'(mb[base + i]) << (8 * i));
            if (!sz[2] && n < 4 && v >= (64'd1 << (8 * n - 1))) v = v + 64'hFFFF_FFFF - ((64'd1 << (8 * n)) - 1);
            rd = 32'(v);
        end
    endfunction

    task automatic txn(input logic we, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input int hold, output logic [31:0] rd);
        logic [31:0] erd, held;
        logic        eerr;
        int          lat;
        model(we, sz, a, wd, erd, eerr);
        req_valid = 1'b1; req_we = we; req_size = sz; req_addr = a; req_wdata = wd;
        rsp_ready = (hold == 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we = $urandom; req_addr = $urandom; req_wdata = $urandom;
        chk("busy_after_accept", 32'(busy), 32'd1);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, W + 1);
        chk("rdata", rsp_rdata, erd);
        chk("err", 32'(rsp_err), 32'(eerr));
        rd = rsp_rdata;
        if (hold > 0) begin
            held = rsp_rdata;
            req_valid = 1'b1; req_we = 1'b1; req_size = 3'b010; req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF;
            repeat (hold) begin
                @(posedge clk); #1;
                chk("hold_valid", 32'(rsp_valid), 32'd1);
                chk("hold_rdata", rsp_rdata, held);
                chk("hold_req_ready", 32'(req_ready), 32'd0);
            end
            req_valid = 1'b0;
            rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("valid_one_cycle", 32'(rsp_valid), 32'd0);
        chk("ready_after_rsp", 32'(req_ready), 32'd1);
        rsp_ready = 1'b0;
    endtask

    logic [31:0] r, saved;
    logic        e;
    initial begin
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        #21 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 64; i++) txn(1'b1, 3'b010, 32'(4 * i), $urandom, 0, r);

        txn(1'b1, 3'b010, 32'h10, 32'h8000_00F0, 0, r);
        txn(1'b0, 3'b010, 32'h10, '0, 0, r);         chk("lw_10", r, 32'h8000_00F0);
        txn(1'b1, 3'b010, 32'h20, 32'h1122_80F0, 0, r);
        txn(1'b0, 3'b000, 32'h20, '0, 0, r);         chk("lb_20", r, 32'hFFFF_FFF0);
        txn(1'b0, 3'b100, 32'h20, '0, 0, r);         chk("lbu_20", r, 32'h0000_00F0);
        txn(1'b0, 3'b001, 32'h22, '0, 0, r);         chk("lh_22", r, 32'h0000_1122);
        txn(1'b0, 3'b101, 32'h20, '0, 0, r);         chk("lhu_20", r, 32'h0000_80F0);
        txn(1'b0, 3'b001, 32'h20, '0, 0, r);         chk("lh_20", r, 32'hFFFF_80F0);
        txn(1'b1, 3'b010, 32'h20, 32'h1122_3344, 0, r);
        txn(1'b1, 3'b000, 32'h21, 32'h0000_00AB, 0, r);
        txn(1'b0, 3'b010, 32'h20, '0, 0, r);         chk("sb_21", r, 32'h1122_AB44);
        txn(1'b1, 3'b001, 32'h22, 32'h0000_BEEF, 0, r);
        txn(1'b0, 3'b010, 32'h20, '0, 0, r);         chk("sh_22", r, 32'hBEEF_AB44);
        txn(1'b0, 3'b010, 32'h1000, '0, 0, r);
        txn(1'b1, 3'b100, 32'h20, 32'h5555_5555, 0, r);
        txn(1'b0, 3'b011, 32'h20, '0, 0, r);
        txn(1'b0, 3'b010, 32'h20, '0, 5, r);         chk("after_errs", r, 32'hBEEF_AB44);

        model(1'b0, 3'b010, 32'h40, '0, saved, e);
        req_valid = 1'b1; req_we = 1'b1; req_size = 3'b010; req_addr = 32'h40; req_wdata = ~saved;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n = 1'b0; #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        #2 rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        txn(1'b0, 3'b010, 32'h40, '0, 0, r);         chk("midrst_word", r, saved);
        txn(1'b0, 3'b010, 32'h06, '0, 0, r);

        for (int i = 0; i < 250; i++) begin
            logic [2:0]  sz;
            logic [31:0] a;
            int unsigned pick;
            pick = $urandom_range(0, 15);
            sz = (pick < 3) ? 3'(pick) : (pick < 5) ? 3'(pick + 1) : (pick == 15) ? 3'($urandom) : 3'($urandom_range(0, 2));
            a = ($urandom_range(0, 15) == 0) ? (32'h1000 + 32'($urandom_range(0, 32'h0FFF_FFFF))) : 32'($urandom_range(0, 255));
            txn($urandom_range(0, 2) == 0, sz, a, $urandom, ($urandom_range(0, 7) == 0) ? 2 : 0, r);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
